// File: rtl/ti_sequencer.sv
// Task-interruption sequencer: freezes the accelerator, grants a save/restore
// interruption (host-requested or breakpoint-triggered) and resumes the task.
module ti_sequencer #(
  parameter int DRAIN_CYCLES = 4,
  parameter int XFER_TIMEOUT = 1024
) (
  input  logic        sys_clk,
  input  logic        sys_resetn,
  input  logic        ti_req,
  input  logic        ti_dir,
  input  logic        pr_done,
  input  logic        ap_start,
  input  logic        ap_done,
  input  logic [31:0] breakpoint,
  output logic        clk_en,
  output logic        ti_gnt,
  output logic        save,
  output logic        restore,
  output logic [31:0] run_cycles,
  output logic        bp_hit,
  output logic        ti_timeout,
  output logic [2:0]  state
);

  // Host handshake: ti_req is a level held until ti_gnt is seen; dropping it
  // before XFER aborts the interruption, dropping it in RESUME ends it.
  // ti_req is ignored during XFER. Breakpoint interruptions resume on their own.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRAIN  = 3'd1,
    S_GRANT  = 3'd2,
    S_XFER   = 3'd3,
    S_RESUME = 3'd4
  } state_t;

  localparam logic [7:0]  DRAIN_LAST = 8'(DRAIN_CYCLES - 1);
  localparam logic [15:0] XFER_LAST  = 16'(XFER_TIMEOUT - 1);
  localparam logic [31:0] BP_OFF     = 32'hFFFF_FFFF;

  state_t      cur, nxt;
  logic        dir_q, dir_d;
  logic        src_bp_q, src_bp_d;
  logic [7:0]  drain_cnt;
  logic [15:0] xfer_cnt;
  logic        running;
  logic        bp_armed;
  logic        ap_start_q;
  logic        start_rise;
  logic        bp_trig;
  logic        xfer_expire;

  assign start_rise  = ap_start && !ap_start_q;
  assign bp_trig     = (cur == S_IDLE) && running && bp_armed &&
                       (breakpoint != BP_OFF) && (run_cycles == breakpoint);
  assign xfer_expire = (cur == S_XFER) && !pr_done && (xfer_cnt == XFER_LAST);
  assign state       = cur;

  always_comb begin
    nxt      = cur;
    dir_d    = dir_q;
    src_bp_d = src_bp_q;
    case (cur)
      S_IDLE: begin
        if (ti_req) begin
          dir_d    = ti_dir;
          src_bp_d = 1'b0;
          nxt      = S_DRAIN;
        end else if (bp_trig) begin
          dir_d    = 1'b0;
          src_bp_d = 1'b1;
          nxt      = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!src_bp_q && !ti_req)        nxt = S_IDLE;
        else if (drain_cnt == DRAIN_LAST) nxt = S_GRANT;
      end
      S_GRANT: begin
        if (!src_bp_q && !ti_req) nxt = S_IDLE;
        else                      nxt = S_XFER;
      end
      S_XFER: begin
        if (pr_done || xfer_expire) nxt = S_RESUME;
      end
      S_RESUME: begin
        if (src_bp_q || !ti_req) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the FSM and never glitch.
  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      cur        <= S_IDLE;
      dir_q      <= 1'b0;
      src_bp_q   <= 1'b0;
      drain_cnt  <= '0;
      xfer_cnt   <= '0;
      clk_en     <= 1'b1;
      ti_gnt     <= 1'b0;
      save       <= 1'b0;
      restore    <= 1'b0;
      ti_timeout <= 1'b0;
    end else begin
      cur        <= nxt;
      dir_q      <= dir_d;
      src_bp_q   <= src_bp_d;
      drain_cnt  <= (cur == S_DRAIN) ? drain_cnt + 8'd1 : '0;
      xfer_cnt   <= (cur == S_XFER) ? xfer_cnt + 16'd1 : '0;
      clk_en     <= (nxt == S_IDLE);
      ti_gnt     <= (nxt == S_GRANT) || (nxt == S_XFER) || (nxt == S_RESUME);
      save       <= (nxt == S_XFER) && !dir_d;
      restore    <= (nxt == S_XFER) && dir_d;
      if (xfer_expire) ti_timeout <= 1'b1;
    end
  end

  // Run tracking; a new run's start takes priority over done and breakpoint.
  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      ap_start_q <= 1'b0;
      running    <= 1'b0;
      bp_armed   <= 1'b0;
      bp_hit     <= 1'b0;
      run_cycles <= '0;
    end else begin
      ap_start_q <= ap_start;
      if (start_rise) begin
        run_cycles <= '0;
        running    <= 1'b1;
        bp_armed   <= 1'b1;
        bp_hit     <= 1'b0;
      end else begin
        if (ap_done) running <= 1'b0;
        if (running && clk_en && (run_cycles != BP_OFF))
          run_cycles <= run_cycles + 32'd1;
        if (bp_trig) begin
          bp_armed <= 1'b0;
          bp_hit   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ti_sequencer.sv
// Bench for ti_sequencer: drivers raise interruptions, a negedge monitor
// condenses each freeze window into a record checked against expected records.
module tb_ti_sequencer;

  localparam int D = 4;
  localparam int T = 1024;

  logic        sys_clk;
  logic        sys_resetn;
  logic        ti_req, ti_dir, pr_done, ap_start, ap_done;
  logic [31:0] breakpoint;
  logic        clk_en, ti_gnt, save, restore, bp_hit, ti_timeout;
  logic [31:0] run_cycles;
  logic [2:0]  state;

  ti_sequencer #(.DRAIN_CYCLES(D), .XFER_TIMEOUT(T)) dut (
    .sys_clk(sys_clk), .sys_resetn(sys_resetn), .ti_req(ti_req), .ti_dir(ti_dir),
    .pr_done(pr_done), .ap_start(ap_start), .ap_done(ap_done), .breakpoint(breakpoint),
    .clk_en(clk_en), .ti_gnt(ti_gnt), .save(save), .restore(restore),
    .run_cycles(run_cycles), .bp_hit(bp_hit), .ti_timeout(ti_timeout), .state(state)
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1000000");
    $fatal(1, "watchdog");
  end

  // one interruption window as seen on the outputs
  typedef struct packed {
    logic [1:0]  kind;    // 0 none, 1 save, 2 restore, 3 both
    logic [7:0]  drain;   // frozen cycles before ti_gnt
    logic [7:0]  pre;     // granted cycles before the strobe
    logic [15:0] strobe;  // strobe cycles
    logic [7:0]  post;    // granted cycles after the strobe
    logic        tmo;
    logic        bp;
    logic        chk_rc;
    logic [31:0] rc;
  } irq_t;

  irq_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   m_tmo = 0;
  bit   m_bp  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_to(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got no response expected DUT event within bound", name);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // scoreboard monitor
  initial begin : monitor
    irq_t got, e;
    bit   in_irq, sv, rs;
    in_irq = 0;
    got = '0;
    sv = 0;
    rs = 0;
    forever begin
      @(negedge sys_clk);
      if (!sys_resetn) begin
        in_irq = 0;
      end else if (!clk_en) begin
        if (!in_irq) begin
          in_irq = 1; got = '0; sv = 0; rs = 0;
          got.rc = run_cycles;
        end
        if (!ti_gnt) got.drain = got.drain + 8'd1;
        else if (save || restore) begin
          got.strobe = got.strobe + 16'd1;
          sv = sv | save;
          rs = rs | restore;
        end
        else if (got.strobe == 0) got.pre = got.pre + 8'd1;
        else got.post = got.post + 8'd1;
      end else if (in_irq) begin
        in_irq   = 0;
        got.kind = {rs, sv};
        got.tmo  = ti_timeout;
        got.bp   = bp_hit;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_irq: got interruption kind %0d expected none", got.kind);
        end else begin
          e = exp_q.pop_front();
          chk("irq_kind",   32'(got.kind),   32'(e.kind));
          chk("irq_drain",  32'(got.drain),  32'(e.drain));
          chk("irq_pre",    32'(got.pre),    32'(e.pre));
          chk("irq_strobe", 32'(got.strobe), 32'(e.strobe));
          chk("irq_post",   32'(got.post),   32'(e.post));
          chk("irq_tmo",    32'(got.tmo),    32'(e.tmo));
          chk("irq_bp_hit", 32'(got.bp),     32'(e.bp));
          if (e.chk_rc) chk("irq_run_cycles", got.rc, e.rc);
        end
      end
    end
  end

  // driver tasks
  task automatic wait_strobe(input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (save || restore) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_to("wait_strobe");
  endtask

  // Called one step after the strobe rose; ends one step after XFER is left.
  task automatic do_xfer(input int len, input bit tmo);
    bit ok;
    ti_dir = 1'($urandom_range(0, 1));
    if (!tmo) begin
      repeat (len - 1) tick();
      pr_done = 1'b1;
      tick();
      pr_done = 1'b0;
    end else begin
      ok = 0;
      for (int i = 0; i < T + 16; i++) begin
        tick();
        if (!(save || restore)) begin
          ok = 1;
          break;
        end
      end
      if (!ok) fail_to("xfer_timeout");
    end
  endtask

  // mode 0: normal, 1: no pr_done (timeout), 2: abort after a edges
  task automatic host_irq(input bit dir, input int mode, input int len, input int hold, input int a);
    irq_t e;
    bit   ok;
    e = '0;
    if (mode == 2) begin
      e.drain = 8'((a <= D) ? a : D);
      e.pre   = (a > D) ? 8'd1 : 8'd0;
    end else begin
      e.kind   = dir ? 2'd2 : 2'd1;
      e.drain  = 8'(D);
      e.pre    = 8'd1;
      e.strobe = (mode == 1) ? 16'(T) : 16'(len);
      e.post   = 8'(hold + 1);
      if (mode == 1) m_tmo = 1;
    end
    e.tmo = m_tmo;
    e.bp  = m_bp;
    exp_q.push_back(e);
    tick();
    ti_req = 1'b1;
    ti_dir = dir;
    if (mode == 2) begin
      repeat (a) tick();
      ti_req = 1'b0;
      tick();
      chk("abort_clk_en", 32'(clk_en), 1);
      chk("abort_gnt", 32'(ti_gnt), 0);
      chk("abort_strobe", 32'({save, restore}), 0);
    end else begin
      wait_strobe(D + 5, ok);
      do_xfer(len, mode == 1);
      repeat (hold) tick();
      ti_req = 1'b0;
      tick();
      chk("resume_clk_en", 32'(clk_en), 1);
      chk("resume_gnt", 32'(ti_gnt), 0);
    end
  endtask

  // Breakpoint run; with simul the host raises a restore on the trigger edge.
  task automatic bp_run(input logic [31:0] b, input int len, input bit simul, input int hold);
    irq_t e;
    bit   ok;
    e = '0;
    e.kind   = simul ? 2'd2 : 2'd1;
    e.drain  = 8'(D);
    e.pre    = 8'd1;
    e.strobe = 16'(len);
    e.post   = simul ? 8'(hold + 1) : 8'd1;
    e.tmo    = m_tmo;
    e.bp     = 1'b1;
    e.chk_rc = 1'b1;
    e.rc     = b + 32'd1;
    breakpoint = b;
    tick();
    ap_start = 1'b1;
    m_bp = 1;
    exp_q.push_back(e);
    if (simul) begin
      repeat (b + 1) tick();
      ti_req = 1'b1;
      ti_dir = 1'b1;
    end
    wait_strobe(int'(b) + 20, ok);
    do_xfer(len, 1'b0);
    if (simul) begin
      repeat (hold) tick();
      ti_req = 1'b0;
    end
    tick();
    chk("bp_resume_clk_en", 32'(clk_en), 1);
    chk("bp_rc_frozen", run_cycles, b + 32'd1);
    repeat (30) tick();
    chk("bp_rc_running", run_cycles, b + 32'd31);
    chk("bp_no_retrigger", 32'(clk_en), 1);
    chk("bp_hit_sticky", 32'(bp_hit), 1);
    ap_done  = 1'b1;
    ap_start = 1'b0;
    tick();
    ap_done = 1'b0;
    repeat (3) tick();
    chk("bp_rc_stopped", run_cycles, b + 32'd32);
    breakpoint = 32'hFFFF_FFFF;
  endtask

  // main stimulus
  initial begin : main
    bit ok;
    sys_resetn = 1'b1;
    ti_req = 0; ti_dir = 0; pr_done = 0; ap_start = 0; ap_done = 0;
    breakpoint = 32'hFFFF_FFFF;
    #1 sys_resetn = 1'b0;
    #1;
    chk("rst_clk_en", 32'(clk_en), 1);
    chk("rst_gnt", 32'(ti_gnt), 0);
    chk("rst_strobes", 32'({save, restore}), 0);
    chk("rst_run_cycles", run_cycles, 0);
    chk("rst_flags", 32'({bp_hit, ti_timeout}), 0);
    chk("rst_state", 32'(state), 0);
    repeat (2) @(negedge sys_clk);
    sys_resetn = 1'b1;

    host_irq(1'b0, 0, 5, 2, 0);
    host_irq(1'b1, 1, 0, 1, 0);
    chk("timeout_sticky", 32'(ti_timeout), 1);
    chk("timeout_idle", 32'(state), 0);
    host_irq(1'b0, 2, 0, 0, 2);

    tick();
    pr_done = 1'b1;
    tick();
    pr_done = 1'b0;
    repeat (3) tick();
    chk("stray_pr_state", 32'(state), 0);
    chk("stray_pr_clk_en", 32'(clk_en), 1);
    chk("stray_pr_gnt", 32'(ti_gnt), 0);

    bp_run(32'd100, $urandom_range(1, 8), 1'b0, 0);

    tick();
    ap_start = 1'b1;
    m_bp = 0;
    repeat (121) tick();
    chk("bp_off_rc", run_cycles, 32'd120);
    chk("bp_off_hit", 32'(bp_hit), 0);
    chk("bp_off_clk_en", 32'(clk_en), 1);
    ap_done  = 1'b1;
    ap_start = 1'b0;
    tick();
    ap_done = 1'b0;

    bp_run(32'($urandom_range(10, 60)), $urandom_range(1, 8), 1'b1, $urandom_range(0, 3));

    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) == 3)
        host_irq(1'b0, 2, 0, 0, $urandom_range(1, D + 1));
      else
        host_irq(1'($urandom_range(0, 1)), 0, $urandom_range(1, 12), $urandom_range(0, 3), 0);
    end

    tick();
    ti_req = 1'b1;
    ti_dir = 1'b0;
    wait_strobe(D + 5, ok);
    #2 sys_resetn = 1'b0;
    #1;
    chk("rst_mid_clk_en", 32'(clk_en), 1);
    chk("rst_mid_save", 32'(save), 0);
    chk("rst_mid_gnt", 32'(ti_gnt), 0);
    chk("rst_mid_timeout", 32'(ti_timeout), 0);
    chk("rst_mid_run_cycles", run_cycles, 0);
    chk("rst_mid_state", 32'(state), 0);
    ti_req = 1'b0;
    m_tmo = 0;
    m_bp  = 0;
    repeat (2) @(negedge sys_clk);
    sys_resetn = 1'b1;
    host_irq(1'($urandom_range(0, 1)), 0, $urandom_range(1, 12), $urandom_range(0, 3), 0);

    repeat (5) tick();
    chk("pending_expected", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
